// File: rtl/set_bit_scanner.sv
// Walks a loaded vector and streams the index of each set bit, one per handshake beat.
// Define SET_BIT_SCANNER_LSB_FIRST_EN for ascending (lowest-first) emission order.

module set_bit_scanner_lod #(
  parameter int unsigned DATA_WD   = 8,
  parameter int unsigned IND_WD    = $clog2(DATA_WD),
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic [DATA_WD-1:0] a_i,
  output logic [IND_WD-1:0]  idx_o
);

  // Later matches overwrite earlier ones, so the scan direction picks the winner.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < DATA_WD; i++) begin
      if (LSB_FIRST) begin
        if (a_i[DATA_WD-1-i]) idx_o = IND_WD'(DATA_WD-1-i);
      end else begin
        if (a_i[i]) idx_o = IND_WD'(i);
      end
    end
  end

endmodule

module set_bit_scanner #(
  parameter int unsigned DATA_WD = 8,
  parameter int unsigned IND_WD  = $clog2(DATA_WD)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [DATA_WD-1:0] i_a,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [IND_WD-1:0]  o_index,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last,
  output logic               o_zero,
  input  logic               i_abort
);

`ifdef SET_BIT_SCANNER_LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_WD-1:0] mask_q, mask_d;
  logic               zero_q, zero_d;
  logic [IND_WD-1:0]  lod_idx;
  logic               single;

  set_bit_scanner_lod #(
    .DATA_WD   (DATA_WD),
    .IND_WD    (IND_WD),
    .LSB_FIRST (LsbFirst)
  ) u_lod (
    .a_i   (mask_q),
    .idx_o (lod_idx)
  );

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign single = (mask_q != '0) && ((mask_q & (mask_q - DATA_WD'(1))) == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    zero_d  = 1'b0;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_last  = 1'b0;
    o_index = lod_idx;
    o_zero  = zero_q;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          if (i_a != '0) begin
            mask_d  = i_a;
            state_d = SCAN;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      SCAN: begin
        o_valid = 1'b1;
        o_last  = single;
        if (i_abort) begin
          state_d = IDLE;
          mask_d  = '0;
        end else if (i_ready) begin
          if (single) begin
            state_d = IDLE;
            mask_d  = '0;
          end else begin
            mask_d = mask_q & ~(DATA_WD'(1) << lod_idx);
          end
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Scoreboard bench for set_bit_scanner: expected beats queued at load, popped on handshake.
// Emission order follows SET_BIT_SCANNER_LSB_FIRST_EN when defined.

module tb_set_bit_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a = '0;
  logic       valid = 1'b0;
  logic       ready = 1'b0;
  logic       abort = 1'b0;
  logic       o_ready, o_valid, o_last, o_zero;
  logic [2:0] o_index;

  typedef struct {
    logic [2:0] idx;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  set_bit_scanner #(.DATA_WD(8), .IND_WD(3)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_a     (a),
    .i_valid (valid),
    .o_ready (o_ready),
    .o_index (o_index),
    .o_valid (o_valid),
    .i_ready (ready),
    .o_last  (o_last),
    .o_zero  (o_zero),
    .i_abort (abort)
  );

  function automatic void push_vec(input logic [7:0] v);
    int order[$];
    for (int i = 0; i < 8; i++) begin
`ifdef SET_BIT_SCANNER_LSB_FIRST_EN
      if (v[i]) order.push_back(i);
`else
      if (v[7-i]) order.push_back(7 - i);
`endif
    end
    for (int k = 0; k < order.size(); k++) begin
      exp_t e;
      e.idx  = 3'(order[k]);
      e.last = (k == order.size() - 1);
      sb.push_back(e);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else passed++;
    total++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_ready); else passed++;
    total++; if (o_last !== 1'b0 || o_zero !== 1'b0) $display("FAIL reset_last_zero: got %b%b want 00", o_last, o_zero); else passed++;
    total++; if (o_index !== 3'd0) $display("FAIL reset_index: got %0d want 0", o_index); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t e;
    int   c;
    a = 8'b1001_0100; valid = 1'b1; ready = 1'b1;
    push_vec(a);
    @(posedge clk);
    @(negedge clk);
    a = 8'hFF;  // offered during SCAN; must be ignored
    for (c = 0; c < 20 && sb.size() > 0; c++) begin
      total++; if (o_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", o_valid); else passed++;
      total++; if (o_ready !== 1'b0) $display("FAIL basic_ready_scan: got %b want 0", o_ready); else passed++;
      e = sb.pop_front();
      total++; if (o_index !== e.idx) $display("FAIL basic_index: got %0d want %0d", o_index, e.idx); else passed++;
      total++; if (o_last !== e.last) $display("FAIL basic_last: got %b want %b", o_last, e.last); else passed++;
      if (e.last) valid = 1'b0;
      @(negedge clk);
    end
    valid = 1'b0;
    total++; if (c != 3) $display("FAIL basic_beats: got %0d want 3", c); else passed++;
    total++; if (o_ready !== 1'b1 || o_valid !== 1'b0) $display("FAIL basic_idle_after: got rdy=%b vld=%b want 1 0", o_ready, o_valid); else passed++;
    sb.delete();
  endtask

  task automatic test_zero();
    a = 8'h00; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (o_zero !== 1'b1) $display("FAIL zero_pulse: got %b want 1", o_zero); else passed++;
    total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) $display("FAIL zero_hs: got vld=%b rdy=%b want 0 1", o_valid, o_ready); else passed++;
    a = 8'h01; ready = 1'b1;
    push_vec(a);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    total++; if (o_zero !== 1'b0) $display("FAIL zero_one_cycle: got %b want 0", o_zero); else passed++;
    total++; if (o_valid !== 1'b1) $display("FAIL zero_next_valid: got %b want 1", o_valid); else passed++;
    if (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      total++; if (o_index !== e.idx || o_last !== e.last) $display("FAIL zero_next_beat: got %0d/%b want %0d/%b", o_index, o_last, e.idx, e.last); else passed++;
    end
    @(negedge clk);
    total++; if (o_valid !== 1'b0) $display("FAIL zero_next_done: got %b want 0", o_valid); else passed++;
    // back-to-back zero loads keep o_zero high every cycle
    a = 8'h00; valid = 1'b1;
    @(posedge clk); @(negedge clk);
    total++; if (o_zero !== 1'b1 || o_ready !== 1'b1) $display("FAIL zero_b2b_1: got z=%b r=%b want 1 1", o_zero, o_ready); else passed++;
    @(posedge clk); @(negedge clk);
    valid = 1'b0;
    total++; if (o_zero !== 1'b1) $display("FAIL zero_b2b_2: got %b want 1", o_zero); else passed++;
    @(negedge clk);
    total++; if (o_zero !== 1'b0) $display("FAIL zero_b2b_end: got %b want 0", o_zero); else passed++;
    sb.delete();
  endtask

  task automatic test_stall();
    exp_t       e;
    int         c;
    int         beats = 0;
    logic       prev_stall = 1'b0;
    logic [2:0] prev_idx = '0;
    a = 8'hFF; valid = 1'b1; ready = 1'b1;
    push_vec(a);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (c = 0; c < 60 && sb.size() > 0; c++) begin
      ready = (c % 4 == 0) || (c % 4 == 3);
      total++; if (o_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", o_valid); else passed++;
      if (prev_stall) begin
        total++; if (o_index !== prev_idx) $display("FAIL stall_hold: got %0d want %0d", o_index, prev_idx); else passed++;
      end
      if (ready) begin
        e = sb.pop_front();
        beats++;
        total++; if (o_index !== e.idx || o_last !== e.last) $display("FAIL stall_beat: got %0d/%b want %0d/%b", o_index, o_last, e.idx, e.last); else passed++;
      end
      prev_stall = !ready;
      prev_idx   = o_index;
      @(negedge clk);
    end
    ready = 1'b1;
    total++; if (beats != 8 || sb.size() != 0) $display("FAIL stall_count: got %0d beats want 8", beats); else passed++;
    total++; if (o_valid !== 1'b0) $display("FAIL stall_end: got %b want 0", o_valid); else passed++;
    sb.delete();
  endtask

  task automatic test_abort();
    exp_t e;
    a = 8'b0110_0001; valid = 1'b1; ready = 1'b1;
    push_vec(a);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    e = sb.pop_front();
    total++; if (o_valid !== 1'b1 || o_index !== e.idx || o_last !== 1'b0) $display("FAIL abort_first: got v=%b %0d/%b want 1 %0d/0", o_valid, o_index, o_last, e.idx); else passed++;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      total++; if (o_valid !== 1'b0 || o_last !== 1'b0 || o_ready !== 1'b1) $display("FAIL abort_quiet: got v=%b l=%b r=%b want 0 0 1", o_valid, o_last, o_ready); else passed++;
      @(negedge clk);
    end
    // abort while idle has no effect on a concurrent load
    a = 8'h02; valid = 1'b1; abort = 1'b1;
    push_vec(a);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; abort = 1'b0;
    e = sb.pop_front();
    total++; if (o_valid !== 1'b1 || o_index !== e.idx || o_last !== e.last) $display("FAIL abort_idle: got v=%b %0d/%b want 1 %0d/%b", o_valid, o_index, o_last, e.idx, e.last); else passed++;
    @(negedge clk);
    sb.delete();
  endtask

  task automatic test_async_reset();
    exp_t e;
    a = 8'hF0; valid = 1'b1; ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    total++; if (o_valid !== 1'b1) $display("FAIL arst_pre: got %b want 1", o_valid); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) $display("FAIL arst_immediate: got v=%b r=%b want 0 1", o_valid, o_ready); else passed++;
    @(negedge clk);
    rst = 1'b0;
    a = 8'h08; valid = 1'b1; ready = 1'b1;
    push_vec(a);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    e = sb.pop_front();
    total++; if (o_valid !== 1'b1 || o_index !== e.idx || o_last !== e.last) $display("FAIL arst_reload: got v=%b %0d/%b want 1 %0d/%b", o_valid, o_index, o_last, e.idx, e.last); else passed++;
    @(negedge clk);
    total++; if (o_valid !== 1'b0) $display("FAIL arst_single: got %b want 0", o_valid); else passed++;
    sb.delete();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1);
  end

endmodule

// File: doc/set_bit_scanner.md
# set_bit_scanner

Sequential controller that walks a loaded bit vector and streams the index of every set bit, one index per handshake beat. The default order is highest set bit first. It wraps a single leading-one-detect datapath instance and sequences it across cycles. Consumers are scheduling and allocation logic that must visit each asserted request or free-slot bit exactly once.

## Interface
- DATA_WD, 8: width of the scanned vector; must be ≥ 2.
- IND_WD, $clog2(DATA_WD): width of an emitted index.
- i_clk  input  1  clock; all state changes on its rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_a  input  DATA_WD  vector to scan; sampled on a load handshake.
- i_valid  input  1  load request.
- o_ready  output  1  load accepted when i_valid && o_ready.
- o_index  output  IND_WD  index of the current set bit.
- o_valid  output  1  o_index valid.
- i_ready  input  1  consumer takes o_index when o_valid && i_ready.
- o_last  output  1  current beat is the final set bit of the vector.
- o_zero  output  1  one-cycle pulse: an all-zero vector was loaded.
- i_abort  input  1  synchronous abort of the scan in progress.

## Operation
- State register: IDLE or SCAN. Internal mask register is DATA_WD bits.
- IDLE:
  - o_ready=1, o_valid=0.
  - On load with i_a≠0: mask←i_a, go to SCAN.
  - On load with i_a==0: stay in IDLE, mask unchanged, o_zero=1 on the next cycle only.
- SCAN:
  - o_ready=0, o_valid=1.
  - o_index = position of the highest set bit of mask, via the leading-one detector.
  - o_last=1 iff mask has exactly one set bit.
  - On output handshake: clear mask[o_index]. If o_last, go to IDLE and mask←0.
  - o_valid and o_index hold stable while i_ready=0.
- i_abort:
  - Acts only in SCAN; ignored in IDLE.
  - Next cycle: state IDLE, mask←0.
  - A beat handshaken in the abort cycle counts as delivered.
  - No further beats and no o_last are produced after the abort cycle.
- Set bits are emitted exactly once each. Beat count equals the popcount of the loaded vector.
- Loading is impossible during SCAN because o_ready=0. i_valid there is ignored and not queued.
- Reset values: state IDLE, mask 0, o_valid 0, o_ready 1, o_last 0, o_zero 0, o_index 0.

## Timing
- Load handshake in cycle N → o_valid=1 in cycle N+1 carrying the first index.
- While i_ready=1, one index per cycle: vector with k set bits delivers beats in N+1 … N+k, with o_last in N+k.
- Last beat in cycle M → o_ready=1 in M+1; the earliest next first beat is M+2.
- o_zero asserts in cycle N+1 for a zero load in cycle N. o_ready stays 1 throughout, so back-to-back zero loads are accepted every cycle.
- o_index and o_last are combinational from registered mask only. There is no combinational path from any input to any output, except o_ready from state.
- Reset asserted mid-scan clears state immediately, without waiting for the clock. Outputs take reset values while i_rst=1.

## Configuration
- SET_BIT_SCANNER_LSB_FIRST_EN:
  - Defined: o_index selects the lowest set bit of mask (trailing-one order). Emission order becomes ascending; all handshake and timing rules are unchanged.
  - Undefined: descending order as specified above.

## Test plan
- Reset then load 8'b1001_0100, i_ready=1 → indices 7,4,2 in cycles N+1..N+3; o_last only with 2; o_ready=1 at N+4.
- Load 8'b0000_0000 → no o_valid; o_zero=1 for exactly cycle N+1; a second load of 8'h01 in N+1 → index 0 with o_last in N+2.
- Load 8'hFF, toggle i_ready 1,0,0,1,… → indices 7..0 each exactly once; o_index stable while stalled; 8 beats total.
- Load 8'b0110_0001, assert i_abort together with the first accepted beat (index 6) → next cycle IDLE, no index 5 or 0, no o_last.
- Assert i_rst between clock edges mid-scan of 8'hF0 → o_valid drops immediately; after release, load 8'h08 → single beat, index 3, o_last=1.
- With SET_BIT_SCANNER_LSB_FIRST_EN defined, load 8'b1001_0100 → indices 2,4,7; o_last with 7.
